fft_out_serializer: RTL and testbench

Parallel-to-serial output stage for the 32-point FFT. It captures one complete frame of 32 complex results from the stage register file in a single cycle. It then streams the frame out one sample per beat on a valid/ready interface, in natural frequency order. It sits between the last butterfly-stage register bank and any word-serial consumer (DMA, UART bridge, test capture).

---
 rtl/fft_out_serializer_if.sv | 22 ++
 rtl/fft_out_serializer.sv | 70 +++++++
 tb/tb_fft_out_serializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_serializer_if.sv
// Load and stream handshake bundle for the FFT output serializer.
interface fft_out_serializer_if #(parameter int bits = 16);
  logic [31:0][2*bits-1:0] in_data;
  logic                    load_valid;
  logic                    load_ready;
  logic [2*bits-1:0]       out_data;
  logic [4:0]              out_index;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output in_data, load_valid, out_ready,
    input  load_ready, out_data, out_index, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, load_valid, out_ready,
    output load_ready, out_data, out_index, out_valid, out_last, busy
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures a 32-sample FFT frame in one cycle and streams it out one bin per
// beat, optionally undoing the bit-reversed order of the butterfly bank.
module fft_out_serializer #(
  parameter int bits    = 16,
  parameter bit BIT_REV = 1'b1
) (
  input logic              clk,
  input logic              reset,
  fft_out_serializer_if.slave io
);
  localparam int W = 2*bits;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic [31:0][W-1:0]  frame_buf;
  logic [W-1:0]        data_q;
  logic                load_ready_q, out_valid_q, out_last_q;

  // Read address for bin c: buffer holds bit-reversed order when BIT_REV is set.
  function automatic logic [4:0] sel(input logic [4:0] c);
    return BIT_REV ? {c[0], c[1], c[2], c[3], c[4]} : c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      frame_buf    <= '0;
      data_q       <= '0;
      load_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.load_valid) begin
          frame_buf    <= io.in_data;
          cnt          <= '0;
          data_q       <= io.in_data[0];  // bin 0 maps to entry 0 in either order
          out_last_q   <= 1'b0;
          load_ready_q <= 1'b0;
          out_valid_q  <= 1'b1;
          state        <= STREAM;
        end
        STREAM: if (io.out_ready) begin
          if (cnt == 5'd31) begin
            cnt          <= '0;
            out_last_q   <= 1'b0;
            load_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt        <= cnt + 5'd1;
            data_q     <= frame_buf[sel(cnt + 5'd1)];
            out_last_q <= (cnt == 5'd30);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.load_ready = load_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.busy       = out_valid_q;
  assign io.out_last   = out_last_q;
  assign io.out_index  = cnt;
  assign io.out_data   = data_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: natural and bit-reversed instances side by side
// against a frame-level model, plus literal spot values.
module tb_fft_out_serializer;
  localparam int bits = 16;
  localparam int W    = 2*bits;

  logic clk = 1'b0;
  logic reset;
  logic lv, ordy;
  logic [31:0][W-1:0] frame;

  always #5 clk = ~clk;

  fft_out_serializer_if #(.bits(bits)) io0 ();
  fft_out_serializer_if #(.bits(bits)) io1 ();

  assign io0.in_data    = frame;
  assign io0.load_valid = lv;
  assign io0.out_ready  = ordy;
  assign io1.in_data    = frame;
  assign io1.load_valid = lv;
  assign io1.out_ready  = ordy;

  fft_out_serializer #(.bits(bits), .BIT_REV(1'b0)) dut0 (.clk(clk), .reset(reset), .io(io0.slave));
  fft_out_serializer #(.bits(bits), .BIT_REV(1'b1)) dut1 (.clk(clk), .reset(reset), .io(io1.slave));

  // Frame-level model: the captured frame, whether a frame is in flight,
  // and how many beats of it have been accepted so far.
  logic [31:0][W-1:0] m_frame;
  bit m_busy, m_zero;
  int m_n;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [4:0] rev5(input logic [4:0] n);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = n[4-i];
    return r;
  endfunction

  task check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task check_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_frame = '0;
    m_busy  = 0;
    m_zero  = 1;
    m_n     = 0;
  endtask

  task model_step();
    if (!m_busy) begin
      if (lv) begin
        m_frame = frame;
        m_busy  = 1;
        m_zero  = 0;
        m_n     = 0;
      end
    end else if (ordy) begin
      if (m_n == 31) m_busy = 0;
      else m_n++;
    end
  endtask

  task compare_one(input string tag, input bit br, input logic lr, input logic ov,
                   input logic bz, input logic ol, input logic [4:0] oi, input logic [W-1:0] od);
    logic [4:0] a;
    check_b({tag, ".load_ready"}, lr, !m_busy);
    check_b({tag, ".out_valid"}, ov, m_busy);
    check_b({tag, ".busy"}, bz, m_busy);
    if (m_busy) begin
      a = br ? rev5(m_n[4:0]) : m_n[4:0];
      check_w({tag, ".out_index"}, W'(oi), W'(m_n));
      check_b({tag, ".out_last"}, ol, m_n == 31);
      check_w({tag, ".out_data"}, od, m_frame[a]);
    end else if (m_zero) begin
      check_w({tag, ".idle_index"}, W'(oi), '0);
      check_b({tag, ".idle_last"}, ol, 1'b0);
      check_w({tag, ".idle_data"}, od, '0);
    end
  endtask

  task compare_all();
    compare_one("nat", 1'b0, io0.load_ready, io0.out_valid, io0.busy, io0.out_last, io0.out_index, io0.out_data);
    compare_one("rev", 1'b1, io1.load_ready, io1.out_valid, io1.busy, io1.out_last, io1.out_index, io1.out_data);
  endtask

  task tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Reset asserted between edges; outputs must fall before any clock edge.
  task do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_b("rst.out_valid_async", io1.out_valid, 1'b0);
    check_b("rst.load_ready_async", io1.load_ready, 1'b1);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task frame_a();
    for (int k = 0; k < 32; k++) frame[k] = {16'(k+1), 16'(-(k+1))};
  endtask

  task frame_c();
    for (int k = 0; k < 32; k++) frame[k] = {16'(k+100), 16'(k)};
  endtask

  task drain(input string name);
    int guard;
    guard = 0;
    while (m_busy && guard < 400) begin
      tick();
      guard++;
    end
    check_b({name, ".drained"}, m_busy, 1'b0);
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    lv    = 1'b0;
    ordy  = 1'b0;
    frame = '0;
    model_reset();
    tick();
    reset = 1'b1;
    tick();

    // Reset with arbitrary inputs present, then idle with load_valid low.
    for (int k = 0; k < 32; k++) frame[k] = W'($urandom);
    ordy = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Natural and bit-reversed readout of the same frame.
    frame_a();
    lv = 1'b1;
    tick();
    lv = 1'b0;
    for (int n = 0; n < 32; n++) begin
      if (n == 0)  check_w("nat.b0", io0.out_data, 32'h0001FFFF);
      if (n == 1)  begin
        check_w("nat.b1", io0.out_data, 32'h0002FFFE);
        check_w("rev.b1", io1.out_data, 32'h0011FFEF);
      end
      if (n == 2)  check_w("rev.b2", io1.out_data, 32'h0009FFF7);
      if (n == 6)  check_w("rev.b6", io1.out_data, 32'h000DFFF3);
      if (n == 31) begin
        check_w("nat.b31", io0.out_data, 32'h0020FFE0);
        check_w("rev.b31", io1.out_data, 32'h0020FFE0);
        check_b("nat.last31", io0.out_last, 1'b1);
      end
      tick();
    end
    check_b("nat.ready_after", io0.load_ready, 1'b1);
    tick();

    // Backpressure, with the parallel inputs scribbled mid-stream.
    for (int k = 0; k < 32; k++) frame[k] = {16'(k*3+7), 16'(k*5+1)};
    lv = 1'b1;
    tick();
    lv = 1'b0;
    waited = 0;
    while (m_busy && waited < 400) begin
      ordy = 1'($urandom_range(0, 1));
      frame[$urandom_range(0, 31)] = W'($urandom);
      tick();
      waited++;
    end
    check_b("bp.drained", m_busy, 1'b0);
    ordy = 1'b1;
    tick();

    // Load request raised at beat 10 waits for the stream to finish.
    frame_a();
    lv = 1'b1;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    frame_c();
    lv = 1'b1;
    waited = 0;
    while (!io0.load_ready && waited < 64) begin
      tick();
      waited++;
    end
    check_w("lds.wait_cycles", W'(waited), 32'd22);
    tick();
    lv = 1'b0;
    check_w("lds.new_b0_nat", io0.out_data, 32'h00640000);
    check_w("lds.new_b0_rev", io1.out_data, 32'h00640000);
    tick();
    check_w("lds.new_b1_nat", io0.out_data, 32'h00650001);
    check_w("lds.new_b1_rev", io1.out_data, 32'h00740010);
    drain("lds");
    tick();

    // Reset at beat 20, then a fresh frame.
    frame_a();
    lv = 1'b1;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_w("rms.beat20", W'(io0.out_index), 32'd20);
    do_reset();
    tick();
    tick();
    check_b("rms.idle", io0.out_valid, 1'b0);
    frame_c();
    lv = 1'b1;
    tick();
    lv = 1'b0;
    check_w("rms.new_b0", io0.out_data, 32'h00640000);
    check_w("rms.new_idx0", W'(io1.out_index), 32'd0);
    drain("rms");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
